parallel2serial: RTL

//  - Transmit side of the serial2parallel link: accepts a WIDTH-bit word via valid/ready.
//  - Shifts the word out LSB-first, one bit per clk, with serial_start marking bit 0.
//  - serial_start/serial_out connect directly to serial2parallel serial_start/serial_in.
//  - Sits between the word-producing logic and the serial2parallel receiver (loopback pair).

---
 rtl/s2p_pkg.sv | 29 ++
 rtl/p2s_bit_counter.sv | 44 ++++
 rtl/parallel2serial.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared definitions for the serial2parallel / parallel2serial link pair:
// default frame width, FSM state encoding and the frame-length helper.
package s2p_pkg;

    localparam int unsigned S2P_WIDTH = 32'd8;

    // State encoding shared by both ends of the link
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SHIFT  = SHIFT,
        ST_PARITY = PARITY
    } s2p_state_e;

    // Number of serial cycles per frame: data bits plus optional parity bit
    function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
        int unsigned len;
        if (parity_en) begin
            len = width + 32'd1;
        end else begin
            len = width;
        end
        return len;
    endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Frame position counter for parallel2serial. Counts the serial cycle
// currently on the line (0 = bit 0), saturates at LAST and flags it.
module p2s_bit_counter #(
    parameter int          CW   = 4,
    parameter int unsigned LAST = 32'd7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          is_last
);

    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, advance while enabled, hold at the last position
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST_C)) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign is_last = (count_q == LAST_C);

endmodule

// File: rtl/parallel2serial.sv
// Transmit side of the serial2parallel link. Accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out LSB first, one bit per clock.
// Optional feature macro: P2S_PARITY_EN appends an even-parity bit per frame.
module parallel2serial
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH = S2P_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_start,
    output logic             serial_out,
    output logic             conversation_end,
    output logic             busy
);

`ifdef P2S_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int unsigned FLEN = frame_len(WIDTH, PAR_EN);
    localparam int          CW   = $clog2(WIDTH + 32'd1);
    // Count value while the final data bit is on the line
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 32'd1);
    // Count value one cycle before the final frame cycle
    localparam logic [CW-1:0] END_PREV  = CW'(FLEN - 32'd2);

    s2p_state_e       state_q;
    logic [WIDTH-1:0] shift_q;
    logic             serial_out_q;
    logic             serial_start_q;
    logic             conv_end_q;
    logic             busy_q;
`ifdef P2S_PARITY_EN
    logic             parity_q;
`endif

    logic [CW-1:0]    count_s;
    logic             is_last_s;
    logic             ready_s;
    logic             accept_s;
    logic             data_last_s;

    // Ready when idle or when the final cycle of the current frame is on the line
    assign ready_s     = (state_q == ST_IDLE) || (busy_q && is_last_s);
    assign accept_s    = load_valid && ready_s;
    assign data_last_s = (count_s == DATA_LAST);

    p2s_bit_counter #(
        .CW   (CW),
        .LAST (FLEN - 32'd1)
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_s),
        .enable  (busy_q && !accept_s),
        .count   (count_s),
        .is_last (is_last_s)
    );

    // Frame FSM: load on accept, shift data bits, optional parity cycle, registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            serial_out_q   <= 1'b0;
            serial_start_q <= 1'b0;
            conv_end_q     <= 1'b0;
            busy_q         <= 1'b0;
`ifdef P2S_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else if (accept_s) begin
            // Bit 0 goes straight to the line; the rest waits in the shifter
            state_q        <= ST_SHIFT;
            shift_q        <= {1'b0, parallel_in[WIDTH-1:1]};
            serial_out_q   <= parallel_in[0];
            serial_start_q <= 1'b1;
            conv_end_q     <= 1'b0;
            busy_q         <= 1'b1;
`ifdef P2S_PARITY_EN
            parity_q       <= ^parallel_in;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (data_last_s) begin
`ifdef P2S_PARITY_EN
                        state_q        <= ST_PARITY;
                        shift_q        <= '0;
                        serial_out_q   <= parity_q;
                        serial_start_q <= 1'b0;
                        conv_end_q     <= 1'b1;
                        busy_q         <= 1'b1;
`else
                        state_q        <= ST_IDLE;
                        shift_q        <= '0;
                        serial_out_q   <= 1'b0;
                        serial_start_q <= 1'b0;
                        conv_end_q     <= 1'b0;
                        busy_q         <= 1'b0;
`endif
                    end else begin
                        state_q        <= ST_SHIFT;
                        shift_q        <= {1'b0, shift_q[WIDTH-1:1]};
                        serial_out_q   <= shift_q[0];
                        serial_start_q <= 1'b0;
                        conv_end_q     <= (count_s == END_PREV);
                        busy_q         <= 1'b1;
                    end
                end
`ifdef P2S_PARITY_EN
                ST_PARITY: begin
                    state_q        <= ST_IDLE;
                    shift_q        <= '0;
                    serial_out_q   <= 1'b0;
                    serial_start_q <= 1'b0;
                    conv_end_q     <= 1'b0;
                    busy_q         <= 1'b0;
                end
`endif
                default: begin
                    state_q        <= ST_IDLE;
                    shift_q        <= '0;
                    serial_out_q   <= 1'b0;
                    serial_start_q <= 1'b0;
                    conv_end_q     <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready       = ready_s;
    assign serial_out       = serial_out_q;
    assign serial_start     = serial_start_q;
    assign conversation_end = conv_end_q;
    assign busy             = busy_q;

endmodule
